task_dispatcher: RTL and testbench

- Consumer end of the scheduler interface: takes the packed per-task processor map and the same exec-time and comm-cost buses the scheduler uses.
- Replays the schedule in a cycle-stepped virtual time base, honouring precedence edges, inter-processor communication delay and one-task-at-a-time per processor.
- Emits a serialized start/finish event stream (valid/ready), then reports makespan.
- Sits downstream of the scheduler's done/processor_assignment outputs; feeds trace/checking logic or core-enable sequencing.

---
 rtl/task_dispatcher_pkg.sv | 27 ++
 rtl/task_dispatcher_if.sv | 29 ++
 rtl/task_dispatcher_proc_slot.sv | 50 +++++
 rtl/task_dispatcher.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_task_dispatcher.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/task_dispatcher_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sched_pkg
//  Description : Shared types and constants for the task dispatcher: FSM
//                state encoding, event kind codes and field widths.
//  Revision    : 1.0  initial release
// ============================================================================
package sched_pkg;

    localparam int PROC_W = 3;
    localparam int TASK_W = 4;

    localparam logic EVT_START  = 1'b0;
    localparam logic EVT_FINISH = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LOAD       = 3'd1,
        S_FIN_SCAN   = 3'd2,
        S_START_SCAN = 3'd3,
        S_EMIT       = 3'd4,
        S_ADVANCE    = 3'd5,
        S_DONE       = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/task_dispatcher_if.sv
`default_nettype none
// ============================================================================
//  Module      : task_dispatcher_if
//  Description : Serialized start/finish event stream with valid/ready.
//  Revision    : 1.0  initial release
// ============================================================================
interface task_dispatcher_if
    import sched_pkg::*;
#(
    parameter int TIME_WIDTH = 16
);
    logic                  evt_valid;
    logic                  evt_ready;
    logic                  evt_kind;
    logic [TASK_W-1:0]     evt_task;
    logic [PROC_W-1:0]     evt_proc;
    logic [TIME_WIDTH-1:0] evt_time;

    modport master (
        output evt_valid, evt_kind, evt_task, evt_proc, evt_time,
        input  evt_ready
    );

    modport slave (
        input  evt_valid, evt_kind, evt_task, evt_proc, evt_time,
        output evt_ready
    );
endinterface
`default_nettype wire

// File: rtl/task_dispatcher_proc_slot.sv
`default_nettype none
// ============================================================================
//  Module      : proc_slot
//  Description : One virtual processor: busy flag, running task and the
//                remaining-time counter with load/decrement/finish controls.
//  Revision    : 1.0  initial release
// ============================================================================
module proc_slot
    import sched_pkg::*;
#(
    parameter int TIME_WIDTH = 16
)(
    input  wire logic                  clk,
    input  wire logic                  reset,
    input  wire logic                  clear,
    input  wire logic                  load,
    input  wire logic [TASK_W-1:0]     load_task,
    input  wire logic [TIME_WIDTH-1:0] load_rem,
    input  wire logic                  dec,
    input  wire logic                  finish,
    output logic                       busy,
    output logic [TASK_W-1:0]          cur_task,
    output logic                       rem_zero
);
    logic                  r_busy;
    logic [TASK_W-1:0]     r_task;
    logic [TIME_WIDTH-1:0] r_rem;

    // Slot state: load a task, retire it, or count its remaining time down
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_busy <= 1'b0;
            r_task <= '0;
            r_rem  <= '0;
        end else if (load) begin
            r_busy <= 1'b1;
            r_task <= load_task;
            r_rem  <= load_rem;
        end else if (finish) begin
            r_busy <= 1'b0;
        end else if (dec && r_busy && (r_rem != '0)) begin
            r_rem <= r_rem - 1'b1;
        end
    end

    assign busy     = r_busy;
    assign cur_task = r_task;
    assign rem_zero = (r_rem == '0);
endmodule
`default_nettype wire

// File: rtl/task_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module      : task_dispatcher
//  Description : Replays a static schedule in virtual time, honouring
//                precedence, communication delay and processor exclusivity,
//                and streams start/finish events, then reports makespan.
//                Optional macro PROC_IDLE_CNT_EN adds per-processor idle
//                step counters on output idle_cnt.
//  Revision    : 1.0  initial release
// ============================================================================
module task_dispatcher
    import sched_pkg::*;
#(
    parameter int          NUM_TASKS      = 10,
    parameter int          NUM_PROCESSORS = 3,
    parameter int          DATA_WIDTH     = 32,
    parameter int          TIME_WIDTH     = 16,
    parameter int unsigned MAX_TIME       = 32'hFFF0
)(
    input  wire logic                                          clk,
    input  wire logic                                          reset,
    input  wire logic                                          start,
    input  wire logic [3*NUM_TASKS-1:0]                        processor_assignment,
    input  wire logic [NUM_PROCESSORS*NUM_TASKS*DATA_WIDTH-1:0] exec_time_in,
    input  wire logic [NUM_TASKS*NUM_TASKS*DATA_WIDTH-1:0]      comm_cost_in,
    task_dispatcher_if.master                                  evt,
    output logic                                               done,
    output logic                                               error,
    output logic [TIME_WIDTH-1:0]                              makespan
`ifdef PROC_IDLE_CNT_EN
    ,
    output logic [NUM_PROCESSORS*TIME_WIDTH-1:0]               idle_cnt
`endif
);
    state_t                                        r_state, w_next_state;
    logic [TIME_WIDTH-1:0]                         r_now;
    logic [PROC_W-1:0]                             r_scan_p;
    logic [NUM_TASKS-1:0]                          r_finished, r_started;
    logic [TIME_WIDTH-1:0]                         r_aft [NUM_TASKS];
    logic [3*NUM_TASKS-1:0]                        r_assign;
    logic [NUM_PROCESSORS*NUM_TASKS*DATA_WIDTH-1:0] r_exec;
    logic [NUM_TASKS*NUM_TASKS*DATA_WIDTH-1:0]      r_comm;
    logic                                          r_evt_kind;
    logic [TASK_W-1:0]                             r_evt_task;
    logic [PROC_W-1:0]                             r_evt_proc;
    logic [TIME_WIDTH-1:0]                         r_evt_time;
    logic                                          r_done, r_error;
    logic [TIME_WIDTH-1:0]                         r_makespan;

    logic                      w_bad_assign, w_last, w_all_fin, w_watchdog;
    logic [NUM_TASKS-1:0]      w_ready;
    logic                      w_pick_found;
    logic [TASK_W-1:0]         w_pick_task;
    logic [DATA_WIDTH-1:0]     w_exec_word;
    logic [TIME_WIDTH-1:0]     w_load_rem, w_now_next;
    logic                      w_cur_busy, w_cur_rem_zero, w_cur_fin, w_start_hit;
    logic [TASK_W-1:0]         w_cur_task;
    logic [NUM_PROCESSORS-1:0] w_slot_busy, w_slot_rem_zero, w_load, w_finish;
    logic [TASK_W-1:0]         w_slot_task [NUM_PROCESSORS];
    logic                      w_clear, w_dec;

    // Earliest admissible start behind a cross-processor edge, saturating at TIME_WIDTH+1 bits
    function automatic logic [TIME_WIDTH:0] need_time(input logic [TIME_WIDTH-1:0] aft,
                                                      input logic [DATA_WIDTH-1:0] cost);
        logic [TIME_WIDTH:0]   d;
        logic [TIME_WIDTH+1:0] s;
        if (cost > DATA_WIDTH'({(TIME_WIDTH+1){1'b1}})) d = '1;
        else                                             d = cost[TIME_WIDTH:0];
        s = {2'b00, aft} + {1'b0, d};
        need_time = s[TIME_WIDTH+1] ? '1 : s[TIME_WIDTH:0];
    endfunction

    // Processor slots, one per virtual processor
    for (genvar p = 0; p < NUM_PROCESSORS; p++) begin : g_slot
        proc_slot #(.TIME_WIDTH(TIME_WIDTH)) u_slot (
            .clk       (clk),
            .reset     (reset),
            .clear     (w_clear),
            .load      (w_load[p]),
            .load_task (w_pick_task),
            .load_rem  (w_load_rem),
            .dec       (w_dec),
            .finish    (w_finish[p]),
            .busy      (w_slot_busy[p]),
            .cur_task  (w_slot_task[p]),
            .rem_zero  (w_slot_rem_zero[p])
        );
    end

    // Readiness of every task against the latched graph and current virtual time
    always_comb begin
        w_ready = '1;
        for (int t = 0; t < NUM_TASKS; t++) begin
            for (int i = 0; i < NUM_TASKS; i++) begin
                if (r_comm[DATA_WIDTH*(NUM_TASKS*i+t) +: DATA_WIDTH] != '0) begin
                    if (!r_finished[i]) begin
                        w_ready[t] = 1'b0;
                    end else if (r_assign[3*i +: 3] == r_assign[3*t +: 3]) begin
                        if (r_now < r_aft[i]) w_ready[t] = 1'b0;
                    end else if ({1'b0, r_now} <
                                 need_time(r_aft[i], r_comm[DATA_WIDTH*(NUM_TASKS*i+t) +: DATA_WIDTH])) begin
                        w_ready[t] = 1'b0;
                    end
                end
            end
        end
    end

    // Scan-point selection: current slot view, lowest ready task, its run length
    always_comb begin
        w_cur_busy     = 1'b0;
        w_cur_rem_zero = 1'b0;
        w_cur_task     = '0;
        w_pick_found   = 1'b0;
        w_pick_task    = '0;
        w_exec_word    = '0;
        w_bad_assign   = 1'b0;
        for (int p = 0; p < NUM_PROCESSORS; p++) begin
            if (PROC_W'(p) == r_scan_p) begin
                w_cur_busy     = w_slot_busy[p];
                w_cur_rem_zero = w_slot_rem_zero[p];
                w_cur_task     = w_slot_task[p];
            end
        end
        for (int t = NUM_TASKS-1; t >= 0; t--) begin
            if ((r_assign[3*t +: 3] == r_scan_p) && !r_started[t] && w_ready[t]) begin
                w_pick_found = 1'b1;
                w_pick_task  = TASK_W'(t);
            end
        end
        for (int p = 0; p < NUM_PROCESSORS; p++) begin
            for (int t = 0; t < NUM_TASKS; t++) begin
                if ((PROC_W'(p) == r_scan_p) && (TASK_W'(t) == w_pick_task))
                    w_exec_word = r_exec[DATA_WIDTH*(NUM_TASKS*p+t) +: DATA_WIDTH];
            end
        end
        for (int t = 0; t < NUM_TASKS; t++) begin
            if (int'(processor_assignment[3*t +: 3]) >= NUM_PROCESSORS) w_bad_assign = 1'b1;
        end
    end

    // Zero-length tasks still occupy one step; overlong ones clip to the time range
    always_comb begin
        if (w_exec_word == '0)                                   w_load_rem = TIME_WIDTH'(1);
        else if (w_exec_word > DATA_WIDTH'({TIME_WIDTH{1'b1}}))  w_load_rem = '1;
        else                                                     w_load_rem = w_exec_word[TIME_WIDTH-1:0];
    end

    assign w_last      = (int'(r_scan_p) == NUM_PROCESSORS-1);
    assign w_all_fin   = &r_finished;
    assign w_now_next  = r_now + 1'b1;
    assign w_watchdog  = (w_now_next == TIME_WIDTH'(MAX_TIME));
    assign w_cur_fin   = w_cur_busy && w_cur_rem_zero;
    assign w_start_hit = !w_cur_busy && w_pick_found;
    assign w_clear     = (r_state == S_LOAD);
    assign w_dec       = (r_state == S_ADVANCE) && !w_all_fin;

    // Per-slot load/finish strobes from the scan position
    always_comb begin
        w_load   = '0;
        w_finish = '0;
        for (int p = 0; p < NUM_PROCESSORS; p++) begin
            if (PROC_W'(p) == r_scan_p) begin
                w_load[p]   = (r_state == S_START_SCAN) && w_start_hit;
                w_finish[p] = (r_state == S_FIN_SCAN) && w_cur_fin;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:       if (start) w_next_state = S_LOAD;
            S_LOAD:       w_next_state = w_bad_assign ? S_DONE : S_FIN_SCAN;
            S_FIN_SCAN:   if (w_cur_fin)   w_next_state = S_EMIT;
                          else if (w_last) w_next_state = S_START_SCAN;
            S_START_SCAN: if (w_start_hit) w_next_state = S_EMIT;
                          else if (w_last) w_next_state = S_ADVANCE;
            S_EMIT: begin
                if (evt.evt_ready) begin
                    if (r_evt_kind == EVT_FINISH) w_next_state = w_last ? S_START_SCAN : S_FIN_SCAN;
                    else                          w_next_state = w_last ? S_ADVANCE : S_START_SCAN;
                end
            end
            S_ADVANCE:    w_next_state = (w_all_fin || w_watchdog) ? S_DONE : S_FIN_SCAN;
            S_DONE:       if (start) w_next_state = S_LOAD;
            default:      w_next_state = S_IDLE;
        endcase
    end

    // Datapath: latched schedule, virtual time, task bookkeeping and event fields
    always_ff @(posedge clk) begin
        if (reset) begin
            r_now      <= '0;
            r_scan_p   <= '0;
            r_finished <= '0;
            r_started  <= '0;
            r_assign   <= '0;
            r_exec     <= '0;
            r_comm     <= '0;
            r_evt_kind <= 1'b0;
            r_evt_task <= '0;
            r_evt_proc <= '0;
            r_evt_time <= '0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_makespan <= '0;
            for (int t = 0; t < NUM_TASKS; t++) r_aft[t] <= '0;
        end else begin
            unique case (r_state)
                S_LOAD: begin
                    r_assign   <= processor_assignment;
                    r_exec     <= exec_time_in;
                    r_comm     <= comm_cost_in;
                    r_now      <= '0;
                    r_scan_p   <= '0;
                    r_finished <= '0;
                    r_started  <= '0;
                    r_makespan <= '0;
                    r_done     <= w_bad_assign;
                    r_error    <= w_bad_assign;
                end
                S_FIN_SCAN: begin
                    if (w_cur_fin) begin
                        for (int t = 0; t < NUM_TASKS; t++) begin
                            if (TASK_W'(t) == w_cur_task) begin
                                r_finished[t] <= 1'b1;
                                r_aft[t]      <= r_now;
                            end
                        end
                        r_evt_kind <= EVT_FINISH;
                        r_evt_task <= w_cur_task;
                        r_evt_proc <= r_scan_p;
                        r_evt_time <= r_now;
                    end else begin
                        r_scan_p <= w_last ? '0 : r_scan_p + 1'b1;
                    end
                end
                S_START_SCAN: begin
                    if (w_start_hit) begin
                        for (int t = 0; t < NUM_TASKS; t++) begin
                            if (TASK_W'(t) == w_pick_task) r_started[t] <= 1'b1;
                        end
                        r_evt_kind <= EVT_START;
                        r_evt_task <= w_pick_task;
                        r_evt_proc <= r_scan_p;
                        r_evt_time <= r_now;
                    end else begin
                        r_scan_p <= w_last ? '0 : r_scan_p + 1'b1;
                    end
                end
                S_EMIT: begin
                    if (evt.evt_ready) r_scan_p <= w_last ? '0 : r_scan_p + 1'b1;
                end
                S_ADVANCE: begin
                    r_scan_p <= '0;
                    if (w_all_fin) begin
                        r_done     <= 1'b1;
                        r_makespan <= r_now;
                    end else begin
                        r_now <= w_now_next;
                        if (w_watchdog) begin
                            r_done     <= 1'b1;
                            r_error    <= 1'b1;
                            r_makespan <= w_now_next;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PROC_IDLE_CNT_EN
    logic [TIME_WIDTH-1:0] r_idle_cnt [NUM_PROCESSORS];

    // Idle step counters: cleared at load, bumped on each time step, saturating
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PROCESSORS; p++) begin
            if (reset || (r_state == S_LOAD))
                r_idle_cnt[p] <= '0;
            else if (w_dec && !w_slot_busy[p] && (r_idle_cnt[p] != '1))
                r_idle_cnt[p] <= r_idle_cnt[p] + 1'b1;
        end
    end

    for (genvar p = 0; p < NUM_PROCESSORS; p++) begin : g_idle_out
        assign idle_cnt[TIME_WIDTH*p +: TIME_WIDTH] = r_idle_cnt[p];
    end
`endif

    assign evt.evt_valid = (r_state == S_EMIT);
    assign evt.evt_kind  = r_evt_kind;
    assign evt.evt_task  = r_evt_task;
    assign evt.evt_proc  = r_evt_proc;
    assign evt.evt_time  = r_evt_time;
    assign done          = r_done;
    assign error         = r_error;
    assign makespan      = r_makespan;
endmodule
`default_nettype wire

// File: tb/tb_task_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module      : tb_task_dispatcher
//  Description : Directed scoreboard bench for task_dispatcher.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_task_dispatcher;
    import sched_pkg::*;

    localparam int NT = 5;
    localparam int NP = 3;
    localparam int DW = 32;
    localparam int TW = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [3*NT-1:0]   pa;
    logic [NP*NT*DW-1:0] ex;
    logic [NT*NT*DW-1:0] cc;
    logic              done, error;
    logic [TW-1:0]     makespan;
`ifdef PROC_IDLE_CNT_EN
    logic [NP*TW-1:0]  idle_cnt;
`endif

    task_dispatcher_if #(.TIME_WIDTH(TW)) ifc();

    task_dispatcher #(
        .NUM_TASKS(NT), .NUM_PROCESSORS(NP), .DATA_WIDTH(DW),
        .TIME_WIDTH(TW), .MAX_TIME(32'hFFF0)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .processor_assignment(pa), .exec_time_in(ex), .comm_cost_in(cc),
        .evt(ifc), .done(done), .error(error), .makespan(makespan)
`ifdef PROC_IDLE_CNT_EN
        , .idle_cnt(idle_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       kind;
        logic [3:0] tsk;
        logic [2:0] prc;
        logic [15:0] tm;
    } ev_t;

    ev_t expq[$];
    int  n_vec = 0;
    int  n_err = 0;
    ev_t held, got, want;
    bit  hold_vld = 0;

    // Monitor: pop expected event on each handshake, check field stability while stalled
    always @(negedge clk) begin
        if (ifc.evt_valid) begin
            got = {ifc.evt_kind, ifc.evt_task, ifc.evt_proc, ifc.evt_time};
            if (hold_vld) begin
                n_vec++;
                if (got !== held) begin
                    n_err++;
                    $display("FAIL evt_stable: got k%0d t%0d p%0d @%0d, held k%0d t%0d p%0d @%0d",
                             got.kind, got.tsk, got.prc, got.tm, held.kind, held.tsk, held.prc, held.tm);
                end
            end
            if (ifc.evt_ready) begin
                n_vec++;
                if (expq.size() == 0) begin
                    n_err++;
                    $display("FAIL evt_unexpected: got k%0d t%0d p%0d @%0d, expected none",
                             got.kind, got.tsk, got.prc, got.tm);
                end else begin
                    want = expq.pop_front();
                    if (got !== want) begin
                        n_err++;
                        $display("FAIL evt: got k%0d t%0d p%0d @%0d, expected k%0d t%0d p%0d @%0d",
                                 got.kind, got.tsk, got.prc, got.tm, want.kind, want.tsk, want.prc, want.tm);
                    end
                end
                hold_vld = 0;
            end else begin
                hold_vld = 1;
                held     = got;
            end
        end else begin
            hold_vld = 0;
        end
    end

    task automatic chk(input string nm, input int act, input int exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic clr_cfg();
        pa = '0; ex = '0; cc = '0;
    endtask
    task automatic set_a(input int t, input int p);
        pa[3*t +: 3] = 3'(p);
    endtask
    task automatic set_x(input int p, input int t, input int v);
        ex[DW*(NT*p+t) +: DW] = DW'(v);
    endtask
    task automatic set_c(input int i, input int j, input int v);
        cc[DW*(NT*i+j) +: DW] = DW'(v);
    endtask
    task automatic extras(input int first);
        for (int t = first; t < NT; t++) begin
            set_a(t, 2);
            set_x(2, t, 1);
        end
    endtask
    task automatic ev(input int k, input int t, input int p, input int tm);
        expq.push_back({1'(k), 4'(t), 3'(p), 16'(tm)});
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask
    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(posedge clk); #1;
            if (done) seen = 1;
        end
        chk("done_seen", int'(seen), 1);
    endtask
    task automatic wait_valid();
        bit seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk); #1;
            if (ifc.evt_valid) seen = 1;
        end
        chk("evt_valid_seen", int'(seen), 1);
    endtask
    task automatic finish_case(input int mk, input int er);
        chk("makespan", int'(makespan), mk);
        chk("error", int'(error), er);
        chk("queue_empty", expq.size(), 0);
    endtask

    task automatic cfg_chain_same();
        clr_cfg();
        set_a(0, 0); set_a(1, 0);
        set_x(0, 0, 3); set_x(0, 1, 4);
        set_c(0, 1, 5);
        extras(2);
    endtask
    task automatic exp_chain_same();
        ev(0,0,0,0); ev(0,2,2,0);
        ev(1,2,2,1); ev(0,3,2,1);
        ev(1,3,2,2); ev(0,4,2,2);
        ev(1,0,0,3); ev(1,4,2,3); ev(0,1,0,3);
        ev(1,1,0,7);
    endtask

    initial begin
        ifc.evt_ready = 1'b1;
        clr_cfg();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_evt_valid", int'(ifc.evt_valid), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_error", int'(error), 0);
        chk("rst_makespan", int'(makespan), 0);
        reset = 1'b0;

        // Out-of-range assignment: error two cycles after start, no events
        clr_cfg();
        set_a(4, 3);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("bad_done_c1", int'(done), 0);
        @(posedge clk); #1;
        chk("bad_done_c2", int'(done), 1);
        chk("bad_error", int'(error), 1);
        chk("bad_valid", int'(ifc.evt_valid), 0);
        repeat (5) @(posedge clk);
        #1 chk("bad_queue_empty", expq.size(), 0);

        // Chain 0->1 on the same processor
        cfg_chain_same();
        exp_chain_same();
        pulse_start();
        wait_done();
        finish_case(7, 0);

        // Chain 0->1 across processors: comm delay applies
        cfg_chain_same();
        set_a(1, 1); set_x(1, 1, 4);
        ev(0,0,0,0); ev(0,2,2,0);
        ev(1,2,2,1); ev(0,3,2,1);
        ev(1,3,2,2); ev(0,4,2,2);
        ev(1,0,0,3); ev(1,4,2,3);
        ev(0,1,1,8);
        ev(1,1,1,12);
        pulse_start();
        wait_done();
        finish_case(12, 0);

        // Fork 0->1, 0->2 on one processor: lowest index first
        clr_cfg();
        set_a(0, 0); set_a(1, 0); set_a(2, 0);
        set_x(0, 0, 2); set_x(0, 1, 2); set_x(0, 2, 2);
        set_c(0, 1, 7); set_c(0, 2, 7);
        extras(3);
        ev(0,0,0,0); ev(0,3,2,0);
        ev(1,3,2,1); ev(0,4,2,1);
        ev(1,0,0,2); ev(1,4,2,2); ev(0,1,0,2);
        ev(1,1,0,4); ev(0,2,0,4);
        ev(1,2,0,6);
        pulse_start();
        wait_done();
        finish_case(6, 0);

        // Independent tasks with backpressure: time frozen while stalled
        clr_cfg();
        set_a(0, 0); set_x(0, 0, 3);
        set_a(1, 1); set_x(1, 1, 3);
        extras(2);
        ev(0,0,0,0); ev(0,1,1,0); ev(0,2,2,0);
        ev(1,2,2,1); ev(0,3,2,1);
        ev(1,3,2,2); ev(0,4,2,2);
        ev(1,0,0,3); ev(1,1,1,3); ev(1,4,2,3);
        ifc.evt_ready = 1'b0;
        pulse_start();
        wait_valid();
        repeat (10) @(posedge clk);
        #1 ifc.evt_ready = 1'b1;
        wait_done();
        finish_case(3, 0);

        // Reset while an event is pending, then a clean rerun
        cfg_chain_same();
        ifc.evt_ready = 1'b0;
        pulse_start();
        wait_valid();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_valid", int'(ifc.evt_valid), 0);
        chk("abort_done", int'(done), 0);
        reset = 1'b0;
        ifc.evt_ready = 1'b1;
        exp_chain_same();
        pulse_start();
        wait_done();
        finish_case(7, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
